debounced_updown_counter_n: RTL

- Parametrised successor to the four-bit debounced up/down/load counter.
- Runs entirely in the systemClock domain: the derived ripple clock is replaced by a one-cycle clock-enable tick.
- Generalised width, configurable debounce depth, selectable wrap or saturate mode, boundary flags.
- Sits between board buttons/switches and display/LED logic in the DebouncedCounter project.

---
 rtl/debounced_updown_counter_n.sv | 80 ++++++++
 1 files changed

// File: rtl/debounced_updown_counter_n.sv
// debounced_updown_counter_n: debounced up/down/load counter with wrap or saturate and boundary flags
module debounced_updown_counter_n #(
  parameter int WIDTH            = 4,
  parameter int SCALER_BITS      = 20,
  parameter int DEBOUNCE_SAMPLES = 3,
  parameter bit WRAP             = 1'b1
) (
  input  logic             systemClock,
  input  logic             resetButton,
  input  logic             upButton,
  input  logic             downButton,
  input  logic             loadButton,
  input  logic [WIDTH-1:0] switches,
  output logic [WIDTH-1:0] counter,
  output logic             atMax,
  output logic             atMin,
  output logic             sampleTick
);
  localparam int N = DEBOUNCE_SAMPLES;
  // button index: 0 = up, 1 = down, 2 = load
  logic [2:0]             btn_s1_q, btn_s2_q;
  logic [WIDTH-1:0]       sw_s1_q, sw_s2_q;
  logic [SCALER_BITS-1:0] presc_q, presc_d;
  logic [2:0][N-1:0]      hist_q, hist_d;
  logic [2:0]             deb_q, deb_d, prev_q, press;
  logic [WIDTH-1:0]       cnt_q, cnt_d;
  logic                   at_max_q, at_max_d, at_min_q, at_min_d;
  logic                   tick, up_ok, dn_ok;
  // prescaler tick, per-button debounce, press edges and counter next state
  always_comb begin
    presc_d = presc_q + 1'b1;
    tick    = &presc_q;
    hist_d  = hist_q;
    deb_d   = deb_q;
    for (int i = 0; i < 3; i++) begin
      if (tick) hist_d[i] = {hist_q[i][N-2:0], btn_s2_q[i]};
      deb_d[i] = &hist_d[i] ? 1'b1 : ~|hist_d[i] ? 1'b0 : deb_q[i];
    end
    press    = deb_q & ~prev_q;
    up_ok    = WRAP || !(&cnt_q);
    dn_ok    = WRAP || (|cnt_q);
    cnt_d    = press[2]                           ? sw_s2_q :
               (press[0] && !press[1] && up_ok)   ? cnt_q + 1'b1 :
               (press[1] && !press[0] && dn_ok)   ? cnt_q - 1'b1 : cnt_q;
    at_max_d = &cnt_d;
    at_min_d = ~|cnt_d;
  end
  // all state registers; reset clears everything except the at-min flag
  always_ff @(posedge systemClock or negedge resetButton) begin
    if (!resetButton) begin
      btn_s1_q <= '0;
      btn_s2_q <= '0;
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
      presc_q  <= '0;
      hist_q   <= '0;
      deb_q    <= '0;
      prev_q   <= '0;
      cnt_q    <= '0;
      at_max_q <= 1'b0;
      at_min_q <= 1'b1;
    end else begin
      btn_s1_q <= {loadButton, downButton, upButton};
      btn_s2_q <= btn_s1_q;
      sw_s1_q  <= switches;
      sw_s2_q  <= sw_s1_q;
      presc_q  <= presc_d;
      hist_q   <= hist_d;
      deb_q    <= deb_d;
      prev_q   <= deb_q;
      cnt_q    <= cnt_d;
      at_max_q <= at_max_d;
      at_min_q <= at_min_d;
    end
  end
  assign counter    = cnt_q;
  assign atMax      = at_max_q;
  assign atMin      = at_min_q;
  assign sampleTick = tick;
endmodule
